// File: rtl/ox_disp_pkg.sv
// Shared definitions for the OX display path: mode codes, ms-to-cycle helper, BCD clip value.
package ox_disp_pkg;

  typedef enum logic [1:0] {
    MODE_INPUT  = 2'd0,
    MODE_TRAIN  = 2'd1,
    MODE_DONE   = 2'd2,
    MODE_RESULT = 2'd3
  } mode_e;

  localparam int unsigned BCD_CLIP = 99;
  localparam int unsigned PROB_MAX = 100;

  // Never returns 0 so a hold always lasts at least one cycle at low clock rates.
  function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
    int unsigned c;
    c = (clk_hz / 1000) * ms;
    return (c == 0) ? 1 : c;
  endfunction

endpackage

// File: rtl/bcd2_clip.sv
// Binary 0..255 to two BCD digits {tens, ones}, saturating at 99.
module bcd2_clip
  import ox_disp_pkg::*;
(
  input  logic [7:0] val,
  output logic [7:0] bcd_c
);

  logic [7:0] v_c;

  always_comb begin
    v_c   = (val > 8'(BCD_CLIP)) ? 8'(BCD_CLIP) : val;
    bcd_c = {4'(v_c / 8'd10), 4'(v_c % 8'd10)};
  end

endmodule

// File: rtl/display_mode_ctrl.sv
// Display mode arbiter: input echo, training progress, done banner and held classification result.
module display_mode_ctrl
  import ox_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned DONE_HOLD_MS   = 3000,
  parameter int unsigned LED_FLASH_MS   = 1000,
  parameter int unsigned RESULT_HOLD_MS = 3000,
  parameter int unsigned CHASE_STEP_CYC = 500000,
  parameter int unsigned LED_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             training_active,
  input  logic             training_done,
  input  logic [7:0]       epoch,
  input  logic             submit,
  input  logic             nn_y,
  input  logic [6:0]       prob_pct,
  input  logic [15:0]      in_disp,
  input  logic             in_valid,
  output logic [15:0]      seg_data,
  output logic             seg_valid,
  output logic             seg_number_mode,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode
);

  localparam int unsigned DONE_CYC  = ms_to_cyc(CLK_HZ, DONE_HOLD_MS);
  localparam int unsigned FLASH_CYC = ms_to_cyc(CLK_HZ, LED_FLASH_MS);
  localparam int unsigned RES_CYC   = ms_to_cyc(CLK_HZ, RESULT_HOLD_MS);
  localparam int unsigned HOLD_MAX  = (DONE_CYC > RES_CYC) ? DONE_CYC : RES_CYC;
  localparam int unsigned TW        = $clog2(HOLD_MAX) + 1;
  localparam int unsigned CW        = $clog2(CHASE_STEP_CYC) + 1;
  localparam int unsigned IW        = $clog2(LED_W) + 1;

  mode_e            state_q, state_d;
  logic             armed_q, done_q, sub_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    chase_cnt_q, chase_cnt_d;
  logic [IW-1:0]    chase_idx_q, chase_idx_d;
  logic             res_y_q, res_y_d;
  logic [6:0]       res_p_q, res_p_d;

  logic             done_rise_c, sub_rise_c;
  logic [6:0]       prob_clip_c;
  logic [7:0]       epoch_bcd_c, prob_bcd_c;
  logic [31:0]      bar_lit_c;
  logic [LED_W-2:0] bar_c;

  logic [15:0]      seg_data_d;
  logic             seg_valid_d, seg_number_mode_d;
  logic [LED_W-1:0] led_d;

  // The armed flag keeps a level already high at reset release from looking like an edge.
  assign done_rise_c = armed_q & training_done & ~done_q;
  assign sub_rise_c  = armed_q & submit & ~sub_q;
  assign prob_clip_c = (prob_pct > 7'(PROB_MAX)) ? 7'(PROB_MAX) : prob_pct;
  assign mode        = state_q;

  bcd2_clip u_epoch_bcd (.val(epoch),            .bcd_c(epoch_bcd_c));
  bcd2_clip u_prob_bcd  (.val({1'b0, res_p_d}),  .bcd_c(prob_bcd_c));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MODE_INPUT;
    else      state_q <= state_d;
  end

  // Next state, hold timer, chase position and result capture.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    chase_cnt_d = chase_cnt_q;
    chase_idx_d = chase_idx_q;
    res_y_d     = res_y_q;
    res_p_d     = res_p_q;

    if (done_rise_c) begin
      state_d = MODE_DONE;
      timer_d = '0;
    end else begin
      case (state_q)
        MODE_DONE: begin
          if (timer_q == TW'(DONE_CYC - 1)) state_d = training_active ? MODE_TRAIN : MODE_INPUT;
          else                              timer_d = timer_q + TW'(1);
        end
        MODE_TRAIN: begin
          if (!training_active) begin
            state_d = MODE_INPUT;
          end else if (chase_cnt_q == CW'(CHASE_STEP_CYC - 1)) begin
            chase_cnt_d = '0;
            chase_idx_d = (chase_idx_q == IW'(LED_W - 1)) ? '0 : chase_idx_q + IW'(1);
          end else begin
            chase_cnt_d = chase_cnt_q + CW'(1);
          end
        end
        MODE_RESULT: begin
          if (training_active) begin
            state_d = MODE_TRAIN;
          end else if (submit) begin
            timer_d = '0;
            res_y_d = nn_y;
            res_p_d = prob_clip_c;
          end else if (timer_q == TW'(RES_CYC - 1)) begin
            state_d = MODE_INPUT;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          if (training_active) begin
            state_d = MODE_TRAIN;
          end else if (sub_rise_c) begin
            state_d = MODE_RESULT;
            timer_d = '0;
            res_y_d = nn_y;
            res_p_d = prob_clip_c;
          end
        end
      endcase
    end

    if (state_d == MODE_TRAIN && state_q != MODE_TRAIN) begin
      chase_cnt_d = '0;
      chase_idx_d = '0;
    end
  end

  // Probability bar: at least one LED lit, otherwise floor(p*(LED_W-1)/100).
  always_comb begin
    bar_lit_c = (32'(res_p_d) * (LED_W - 1)) / 32'd100;
    if (bar_lit_c == 32'd0) bar_lit_c = 32'd1;
    bar_c = '0;
    for (int i = 0; i < int'(LED_W) - 1; i++) bar_c[i] = (unsigned'(i) < bar_lit_c);
  end

  // Output word for the state being entered on this edge.
  always_comb begin
    seg_data_d        = '0;
    seg_valid_d       = 1'b0;
    seg_number_mode_d = 1'b0;
    led_d             = '0;
    case (state_d)
      MODE_DONE: begin
        seg_data_d        = 16'h0099;
        seg_valid_d       = 1'b1;
        seg_number_mode_d = 1'b1;
        led_d             = (32'(timer_d) < FLASH_CYC) ? '1 : '0;
      end
      MODE_TRAIN: begin
        seg_data_d        = {8'h00, epoch_bcd_c};
        seg_valid_d       = 1'b1;
        seg_number_mode_d = 1'b1;
        led_d             = LED_W'(1) << chase_idx_d;
      end
      MODE_RESULT: begin
        seg_data_d        = {8'h00, prob_bcd_c};
        seg_valid_d       = 1'b1;
        seg_number_mode_d = 1'b1;
        led_d             = {res_y_d, bar_c};
      end
      default: begin
        seg_data_d  = in_disp;
        seg_valid_d = in_valid;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q         <= 1'b0;
      done_q          <= 1'b0;
      sub_q           <= 1'b0;
      timer_q         <= '0;
      chase_cnt_q     <= '0;
      chase_idx_q     <= '0;
      res_y_q         <= 1'b0;
      res_p_q         <= '0;
      seg_data        <= '0;
      seg_valid       <= 1'b0;
      seg_number_mode <= 1'b0;
      led             <= '0;
    end else begin
      armed_q         <= 1'b1;
      done_q          <= training_done;
      sub_q           <= submit;
      timer_q         <= timer_d;
      chase_cnt_q     <= chase_cnt_d;
      chase_idx_q     <= chase_idx_d;
      res_y_q         <= res_y_d;
      res_p_q         <= res_p_d;
      seg_data        <= seg_data_d;
      seg_valid       <= seg_valid_d;
      seg_number_mode <= seg_number_mode_d;
      led             <= led_d;
    end
  end

endmodule

// File: doc/display_mode_ctrl.md
# display_mode_ctrl

Parametrised presentation controller that sits between the training controller / MLP classifier and the 7-segment / LED drivers. It arbitrates four display modes: input echo, training progress, training-complete banner and classification result. It owns all hold timers and the LED chase and bar generation, and it formats numeric values as two-digit BCD. New relative to the previous inline logic:

- clock-frequency-derived timers;
- configurable LED width;
- the result is latched and held for a programmable time after submit is released.

## Interface

Parameters:

- CLK_HZ, 50000000, clock frequency in Hz.
- DONE_HOLD_MS, 3000, duration of the "99" banner after training completes.
- LED_FLASH_MS, 1000, duration of all-LEDs-on at training complete.
- RESULT_HOLD_MS, 3000, how long the result stays visible after submit is released.
- CHASE_STEP_CYC, 500000, cycles per LED chase step during training.
- LED_W, 8, LED count; must be at least 2.

Ports:

- clk, in, 1, system clock.
- rst, in, 1, reset; one clock domain, asynchronous, active-low.
- training_active, in, 1, training in progress (level).
- training_done, in, 1, training complete (level; only its rising edge is used).
- epoch, in, 8, current epoch number.
- submit, in, 1, submit button (level, already debounced).
- nn_y, in, 1, classifier decision: 1 = O, 0 = X.
- prob_pct, in, 7, probability of O in percent; valid range 0–100, larger values are clipped to 100.
- in_disp, in, 16, one-hot input flags to echo.
- in_valid, in, 1, input echo valid.
- seg_data, out, 16, display word for the segment driver.
- seg_valid, out, 1, display word valid.
- seg_number_mode, out, 1, 1 = BCD number mode, 0 = one-hot mode.
- led, out, LED_W, LED pattern.
- mode, out, 2, current state: 0 INPUT, 1 TRAIN, 2 DONE, 3 RESULT.

## Operation

States and priority (highest first):

- DONE: entered on the training_done rising edge from any state. The DONE and flash timers restart.
- TRAIN: entered while training_active=1 and the state is not DONE.
- RESULT: entered on the submit rising edge when training_active=0.
- INPUT: default state.

Behaviour by state:

- **DONE:**
  - seg_data = 16'h0099, seg_number_mode=1, seg_valid=1.
  - led all ones until LED_FLASH_MS elapses, then all zeros.
  - Exit after DONE_HOLD_MS to TRAIN if training_active=1, otherwise to INPUT.
- **TRAIN:**
  - seg_data = {8'h00, tens, ones} of epoch; epoch ≥ 99 is shown as 99. seg_number_mode=1, seg_valid=1.
  - led is a single-hot chase: bit 0 first, advances one bit every CHASE_STEP_CYC cycles, wraps from LED_W-1 to 0.
  - The chase position resets to bit 0 on TRAIN entry.
  - Exit to INPUT when training_active falls.
- **RESULT:**
  - On entry and on every cycle while submit=1, nn_y and prob_pct are captured into result registers.
  - seg_data = BCD of the captured probability, with 100 shown as 99. seg_number_mode=1, seg_valid=1.
  - led[LED_W-1] = captured nn_y.
  - led[LED_W-2:0] is a bar: lit = max(1, floor(p·(LED_W-1)/100)), where p is the captured probability. The lowest `lit` bits are 1.
  - The hold timer starts when submit falls. Exit to INPUT after RESULT_HOLD_MS.
  - A new submit rising edge during the hold clears the timer and resumes live capture.
  - A training_active rise exits to TRAIN.
- **INPUT:**
  - seg_data = in_disp, seg_number_mode=0, seg_valid=in_valid, led all zeros.

Timer rules:

- Cycle counts are computed as CLK_HZ/1000·ms, elaborated at compile time.
- Counter widths are $clog2 of the largest count plus 1.
- A timer reaching count-1 causes the exit on the next edge.

## Timing

- All outputs are registered. Output values reflect the inputs sampled on the previous edge, i.e. 1-cycle latency.
- Edge detection uses one previous-value register per edge input; the edge is acted on in the cycle after it is sampled.
- Reset values: mode=0, seg_data=0, seg_valid=0, seg_number_mode=0, led=0. All timers, the chase index and the result registers are 0.
- Reset mid-hold or mid-training aborts immediately. After reset release, a training_done level that is already high is not treated as an edge.
- If the training_done rise and the submit rise occur in the same cycle, DONE wins and the submit edge is dropped.
- If training_done re-rises while in DONE, the DONE and flash timers restart.
- RESULT with submit held indefinitely has no timeout.

## Structure

Shared package ox_disp_pkg:

- mode encodings;
- the ms-to-cycles constant function;
- the BCD clip value 99.

Sub-module bcd2_clip (7/8-bit value to {tens, ones}, clipped at 99): combinational, instantiated twice, once for epoch and once for the captured probability. The FSM, timers, chase and bar logic stay in this block.

## Test plan

Run at CLK_HZ=1000 so that 1 ms = 1 cycle.

- **Reset:** reset, then release with training_done=1 → mode stays 0, led=0, no "99" shown.
- **Training and banner:** training_active=1, epoch=7 → seg_data=0x0007, seg_number_mode=1. led advances one bit every CHASE_STEP_CYC and wraps after LED_W steps. Then training_done rises → seg_data=0x0099. led=all ones for 1000 cycles, then 0. Mode returns to 0 after 3000 cycles.
- **Result hold:** submit pulse, nn_y=1, prob_pct=100 → seg_data=0x0099 and led=8'hFF (LED_W=8). Change prob_pct to 20 after submit falls → display stays 0x0099 for 3000 cycles, then mode=0.
- **Bar boundaries (LED_W=8):** prob 0 → led[6:0]=0000001; 14 → 0000001; 15 → 0000001; 29 → 0000011; 57 → 0000111. Values follow floor(p·7/100) with a minimum of 1.
- **Collisions:** submit rise in the same cycle as the training_done rise → DONE. A submit rise during the RESULT hold → timer cleared and live capture resumes. A training_active rise during the hold → TRAIN.
- **Input echo:** in INPUT with in_valid=1, in_disp=16'h0400 → seg_data=0x0400, seg_number_mode=0, seg_valid=1.
